// File: rtl/shift_arb_pkg.sv
// Shared constants and transaction types for the shift-request arbiter.
// Widths default to the FHE datapath operand size.
package shift_arb_pkg;

   localparam int BIT_WIDTH_DEF = 108;
   localparam int SHAMT_W       = 7;
   localparam int ID_W_MAX      = 3;

   typedef struct packed {
      logic [BIT_WIDTH_DEF-1:0] data;
      logic [SHAMT_W-1:0]       shamt;
   } shift_req_t;

   typedef struct packed {
      logic [ID_W_MAX-1:0]      id;
      logic [BIT_WIDTH_DEF-1:0] data;
   } shift_rsp_t;

   // Round-robin successor of a requester index.
   function automatic int rr_next(input int idx, input int n);
      int nxt;
      if (idx + 1 >= n) begin
         nxt = 0;
      end else begin
         nxt = idx + 1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/fhe_rshift.sv
// Combinational logical right shifter; shift amounts at or beyond the
// operand width produce zero.
module fhe_rshift #(
   parameter int W = 108,
   parameter int K = 7
) (
   input  logic [W-1:0] din,
   input  logic [K-1:0] k,
   output logic [W-1:0] dout
);

   // Zero-fill shift with explicit saturation to all-zero.
   always_comb begin
      dout = '0;
      if (int'(k) >= W) begin
         dout = '0;
      end else begin
         dout = din >> k;
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid
);

   logic [IW:0] idx_s;

   // Scan requesters starting at ptr; the first hit wins.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx_s       = '0;
      for (int k = 0; k < N; k++) begin
         idx_s = {1'b0, ptr} + (IW+1)'(k);
         if (idx_s >= (IW+1)'(N)) begin
            idx_s = idx_s - (IW+1)'(N);
         end else begin
            idx_s = idx_s;
         end
         if (!grant_valid && req[idx_s[IW-1:0]]) begin
            grant_valid               = 1'b1;
            grant[idx_s[IW-1:0]]      = 1'b1;
            grant_idx                 = idx_s[IW-1:0];
         end else begin
            grant_valid = grant_valid;
         end
      end
   end

endmodule

// File: rtl/shift_req_arbiter.sv
// Round-robin arbiter feeding a two-stage issue/result pipeline around one
// shared right-shifter, with full response back-pressure.
module shift_req_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int BIT_WIDTH = shift_arb_pkg::BIT_WIDTH_DEF,
   parameter int SHAMT_W   = shift_arb_pkg::SHAMT_W,
   parameter int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*SHAMT_W-1:0]   req_shamt,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [ID_W-1:0]              rsp_id,
   output logic [BIT_WIDTH-1:0]         rsp_data
);

   import shift_arb_pkg::*;

   logic                 s1_valid_r, s2_valid_r;
   logic [ID_W-1:0]      s1_id_r, s2_id_r, rr_ptr_r;
   logic [BIT_WIDTH-1:0] s1_data_r, s2_data_r;
   logic [SHAMT_W-1:0]   s1_shamt_r;

   logic                 s1_en_s, s2_en_s, fire_s, grant_valid_s;
   logic [NUM_REQ-1:0]   grant_s;
   logic [ID_W-1:0]      grant_idx_s;
   logic [BIT_WIDTH-1:0] sel_data_s, shift_out_s;
   logic [SHAMT_W-1:0]   sel_shamt_s;

   assign s2_en_s = !s2_valid_r || rsp_ready;
   assign s1_en_s = !s1_valid_r || s2_en_s;
   assign fire_s  = grant_valid_s && s1_en_s;

   // Ready is suppressed while reset is held so nothing can be accepted.
   assign req_ready = (rstn && s1_en_s) ? grant_s : {NUM_REQ{1'b0}};

   rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
      .req         (req_valid),
      .ptr         (rr_ptr_r),
      .grant       (grant_s),
      .grant_idx   (grant_idx_s),
      .grant_valid (grant_valid_s)
   );

   // One-hot AND-OR mux of the winner's operand and shift amount.
   always_comb begin
      sel_data_s  = '0;
      sel_shamt_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_data_s  = sel_data_s  | ({BIT_WIDTH{grant_s[i]}} & req_data[i*BIT_WIDTH +: BIT_WIDTH]);
         sel_shamt_s = sel_shamt_s | ({SHAMT_W{grant_s[i]}}   & req_shamt[i*SHAMT_W +: SHAMT_W]);
      end
   end

   fhe_rshift #(.W(BIT_WIDTH), .K(SHAMT_W)) u_shift (
      .din  (s1_data_r),
      .k    (s1_shamt_r),
      .dout (shift_out_s)
   );

   // Issue stage and round-robin pointer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_r <= 1'b0;
         s1_id_r    <= '0;
         s1_data_r  <= '0;
         s1_shamt_r <= '0;
         rr_ptr_r   <= '0;
      end else if (s1_en_s) begin
         s1_valid_r <= fire_s;
         if (fire_s) begin
            s1_id_r    <= grant_idx_s;
            s1_data_r  <= sel_data_s;
            s1_shamt_r <= sel_shamt_s;
            rr_ptr_r   <= ID_W'(rr_next(int'(grant_idx_s), NUM_REQ));
         end
      end
   end

   // Result stage; held while the consumer stalls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid_r <= 1'b0;
         s2_id_r    <= '0;
         s2_data_r  <= '0;
      end else if (s2_en_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_id_r   <= s1_id_r;
            s2_data_r <= shift_out_s;
         end
      end
   end

   assign rsp_valid = s2_valid_r;
   assign rsp_id    = s2_id_r;
   assign rsp_data  = s2_data_r;

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Randomized self-checking bench for shift_req_arbiter against a
// transaction-level model of the arbiter and two-slot pipeline.
module tb_shift_req_arbiter;

   localparam int N  = 4;
   localparam int BW = 108;
   localparam int SW = 7;

   logic              clk = 1'b0;
   logic              rstn;
   logic [N-1:0]      req_valid, req_ready;
   logic [N*BW-1:0]   req_data;
   logic [N*SW-1:0]   req_shamt;
   logic              rsp_valid, rsp_ready;
   logic [1:0]        rsp_id;
   logic [BW-1:0]     rsp_data;

   logic [BW-1:0]     d_arr [N];
   logic [SW-1:0]     s_arr [N];
   bit                pend  [N];

   typedef struct {
      bit            v;
      int            id;
      logic [BW-1:0] r;
   } slot_t;

   slot_t m_s1, m_s2;
   int    m_ptr, n_in, n_out, n_checks, n_fail;
   int    id_log [$];

   always #5 clk = ~clk;

   always_comb begin
      req_data  = '0;
      req_shamt = '0;
      for (int i = 0; i < N; i++) begin
         req_data[i*BW +: BW]  = d_arr[i];
         req_shamt[i*SW +: SW] = s_arr[i];
      end
   end

   shift_req_arbiter #(.NUM_REQ(N), .BIT_WIDTH(BW), .SHAMT_W(SW), .ID_W(2)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_shamt (req_shamt),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Shift expressed as repeated halving; saturates to zero naturally.
   function automatic logic [BW-1:0] exp_shift(input logic [BW-1:0] d, input int s);
      logic [BW-1:0] r;
      r = d;
      for (int i = 0; i < s; i++) r = r / 2;
      return r;
   endfunction

   function automatic logic [BW-1:0] rand_data();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[BW-1:0];
   endfunction

   function automatic logic [SW-1:0] rand_shamt();
      logic [SW-1:0] s;
      case ($urandom_range(0, 5))
         0:       s = SW'(0);
         1:       s = SW'(107);
         2:       s = SW'(108);
         3:       s = SW'(127);
         default: s = SW'($urandom_range(0, 127));
      endcase
      return s;
   endfunction

   task automatic gen(input int prob, input bit wd);
      for (int i = 0; i < N; i++) begin
         if (!pend[i]) begin
            if ($urandom_range(0, 99) < prob) begin
               pend[i]  = 1'b1;
               d_arr[i] = rand_data();
               s_arr[i] = rand_shamt();
            end
         end else if (wd && $urandom_range(0, 99) < 4) begin
            pend[i] = 1'b0;
         end
      end
   endtask

   task automatic drive_valid();
      for (int i = 0; i < N; i++) req_valid[i] = pend[i];
   endtask

   // One clock of the reference model; called at a falling edge.
   task automatic step();
      int            g, idx;
      bit            en;
      logic [N-1:0]  exp_ready;
      drive_valid();
      #1;
      check_eq("rsp_valid", 128'(rsp_valid), 128'(m_s2.v));
      if (m_s2.v) begin
         check_eq("rsp_id", 128'(rsp_id), 128'(m_s2.id));
         check_eq("rsp_data", 128'(rsp_data), 128'(m_s2.r));
      end
      en = !(m_s1.v && m_s2.v && !rsp_ready);
      g  = -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (g < 0 && pend[idx]) g = idx;
      end
      exp_ready = '0;
      if (en && g >= 0) exp_ready[g] = 1'b1;
      check_eq("req_ready", 128'(req_ready), 128'(exp_ready));
      if (m_s2.v && rsp_ready) begin
         n_out++;
         id_log.push_back(m_s2.id);
      end
      if (!m_s2.v || rsp_ready) m_s2 = m_s1;
      if (en) begin
         m_s1.v = 1'b0;
         if (g >= 0) begin
            m_s1.v  = 1'b1;
            m_s1.id = g;
            m_s1.r  = exp_shift(d_arr[g], int'(s_arr[g]));
            m_ptr   = (g + 1) % N;
            pend[g] = 1'b0;
            n_in++;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      drive_valid();
      #1;
      check_eq("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      check_eq("rst_req_ready", 128'(req_ready), 128'(0));
      check_eq("rst_rsp_id", 128'(rsp_id), 128'(0));
      check_eq("rst_rsp_data", 128'(rsp_data), 128'(0));
      n_in   = n_in - int'(m_s1.v) - int'(m_s2.v);
      m_s1.v = 1'b0;
      m_s2.v = 1'b0;
      m_ptr  = 0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic fill_all();
      for (int i = 0; i < N; i++) begin
         if (!pend[i]) begin
            pend[i]  = 1'b1;
            d_arr[i] = rand_data();
            s_arr[i] = rand_shamt();
         end
      end
   endtask

   initial begin
      logic [SW-1:0] bsh  [4];
      logic [BW-1:0] bexp [4];
      logic [BW-1:0] ones;
      int            ones_cnt;
      ones    = '1;
      bsh[0]  = SW'(0);   bexp[0] = ones;
      bsh[1]  = SW'(107); bexp[1] = BW'(1);
      bsh[2]  = SW'(108); bexp[2] = '0;
      bsh[3]  = SW'(127); bexp[3] = '0;
      n_checks = 0; n_fail = 0; n_in = 0; n_out = 0; m_ptr = 0;
      m_s1.v = 1'b0; m_s2.v = 1'b0;
      rstn = 1'b0; rsp_ready = 1'b0; req_valid = '0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; d_arr[i] = '0; s_arr[i] = '0;
      end
      @(negedge clk);
      fill_all();
      do_reset();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;

      // Single request from requester 2.
      rsp_ready = 1'b1;
      pend[2] = 1'b1; d_arr[2] = BW'(8'hF0); s_arr[2] = SW'(4);
      step(); step();
      #1;
      check_eq("single_valid", 128'(rsp_valid), 128'(1));
      check_eq("single_id", 128'(rsp_id), 128'(2));
      check_eq("single_data", 128'(rsp_data), 128'(8'h0F));
      step(); step();

      // Boundary shift amounts on an all-ones operand.
      for (int b = 0; b < 4; b++) begin
         pend[0] = 1'b1; d_arr[0] = ones; s_arr[0] = bsh[b];
         step(); step();
         #1;
         check_eq($sformatf("boundary_%0d", bsh[b]), 128'(rsp_data), 128'(bexp[b]));
         step();
      end

      // Fairness from a fresh pointer.
      do_reset();
      id_log.delete();
      for (int c = 0; c < 12; c++) begin
         fill_all();
         step();
      end
      check_eq("fair_count", 128'(id_log.size() >= 8), 128'(1));
      for (int i = 0; i < 8 && i < id_log.size(); i++)
         check_eq($sformatf("fair_%0d", i), 128'(id_log[i]), 128'(i % N));

      // Back-pressure with saturated requesters.
      rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         fill_all();
         step();
      end
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         fill_all();
         step();
      end
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      repeat (4) step();
      check_eq("bp_no_loss", 128'(n_out), 128'(n_in));

      // Withdrawal of requester 1 while 3 holds the grant.
      do_reset();
      id_log.delete();
      rsp_ready = 1'b0;
      pend[2] = 1'b1; d_arr[2] = rand_data(); s_arr[2] = rand_shamt();
      step();
      pend[3] = 1'b1; d_arr[3] = rand_data(); s_arr[3] = rand_shamt();
      pend[1] = 1'b1; d_arr[1] = rand_data(); s_arr[1] = rand_shamt();
      step(); step();
      pend[1] = 1'b0;
      step();
      rsp_ready = 1'b1;
      repeat (4) step();
      ones_cnt = 0;
      foreach (id_log[i]) if (id_log[i] == 1) ones_cnt++;
      check_eq("withdraw_no_id1", 128'(ones_cnt), 128'(0));
      check_eq("withdraw_count", 128'(id_log.size()), 128'(2));
      fill_all();
      drive_valid();
      #1;
      check_eq("withdraw_ptr", 128'(req_ready), 128'(4'b0001));
      repeat (8) step();

      // Random traffic with withdrawals and random back-pressure.
      for (int c = 0; c < 1500; c++) begin
         rsp_ready = ($urandom_range(0, 99) < 70);
         gen(40, 1'b1);
         step();
      end

      // Reset with both stages occupied.
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         fill_all();
         step();
      end
      check_eq("mid_full", 128'(m_s1.v && m_s2.v), 128'(1));
      fill_all();
      do_reset();
      fill_all();
      drive_valid();
      #1;
      check_eq("post_rst_grant", 128'(req_ready), 128'(4'b0001));
      rsp_ready = 1'b1;
      repeat (12) step();
      check_eq("final_no_loss", 128'(n_out), 128'(n_in));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
